// File: rtl/sync_pkg.sv
// Shared types and helpers for the sync offset controller.
// Offsets are 4-bit two's complement; clamping works on a 5-bit sum.
package sync_pkg;

    localparam int OFFW = 4;

    typedef logic signed [OFFW-1:0] off_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } axis_state_e;

    function automatic off_t clamp(
        input logic signed [OFFW:0] v,
        input int                   mn,
        input int                   mx
    );
        off_t r;
        if (int'(v) < mn) begin
            r = off_t'(mn);
        end else if (int'(v) > mx) begin
            r = off_t'(mx);
        end else begin
            r = off_t'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/offset_axis.sv
// One offset axis: button direction decode, frame-based auto-repeat
// FSM and the clamped next value for a step.
module offset_axis
    import sync_pkg::*;
#(
    parameter int MINV      = -8,
    parameter int MAXV      = 7,
    parameter int REP_DELAY = 20,
    parameter int REP_RATE  = 4,
    parameter int FCW       = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vb_rise_i,
    input  logic inc_i,
    input  logic dec_i,
    input  off_t cur_i,
    output logic step_o,
    output off_t nxt_o
);

    axis_state_e          state_q, state_d;
    logic [FCW-1:0]       cnt_q, cnt_d;
    logic                 up_q, up_d;
    logic                 hold;
    logic                 up;
    logic signed [OFFW:0] ext;
    logic signed [OFFW:0] sum;

    assign hold = inc_i ^ dec_i;
    assign up   = inc_i;
    assign ext  = {cur_i[OFFW-1], cur_i};
    // 5-bit sum so that 7+1 and -8-1 saturate instead of wrapping
    assign sum   = up ? ext + (OFFW+1)'(1) : ext - (OFFW+1)'(1);
    assign nxt_o = clamp(sum, MINV, MAXV);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        up_d    = up_q;
        step_o  = 1'b0;
        if (!hold) begin
            state_d = IDLE;
        end else if (vb_rise_i) begin
            unique case (state_q)
                IDLE: begin
                    step_o  = 1'b1;
                    cnt_d   = FCW'(REP_DELAY - 1);
                    state_d = DELAY;
                    up_d    = up;
                end
                DELAY, REPEAT: begin
                    if (up != up_q) begin
                        step_o  = 1'b1;
                        cnt_d   = FCW'(REP_DELAY - 1);
                        state_d = DELAY;
                        up_d    = up;
                    end else if (cnt_q == '0) begin
                        step_o  = 1'b1;
                        cnt_d   = FCW'(REP_RATE - 1);
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
        end
    end

endmodule

// File: rtl/sync_offset_ctrl.sv
// Owns hoffset/voffset for sync_shifter; every change is committed
// on the rising edge of vblank so the shifter never sees a mid-frame step.
module sync_offset_ctrl
    import sync_pkg::*;
#(
    parameter int HMIN      = -8,
    parameter int HMAX      = 7,
    parameter int VMIN      = -8,
    parameter int VMAX      = 7,
    parameter int REP_DELAY = 20,
    parameter int REP_RATE  = 4,
    parameter int FCW       = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vblank_i,
    input  logic                   btn_left_i,
    input  logic                   btn_right_i,
    input  logic                   btn_up_i,
    input  logic                   btn_down_i,
    input  logic                   btn_center_i,
    input  logic                   cfg_valid_i,
    input  logic signed [OFFW-1:0] cfg_h_i,
    input  logic signed [OFFW-1:0] cfg_v_i,
    output logic                   cfg_ready_o,
    output logic signed [OFFW-1:0] hoffset_o,
    output logic signed [OFFW-1:0] voffset_o,
    output logic                   changed_o
);

    logic vblank_q;
    logic center_q;
    logic pend_q, pend_d;
    logic ready_q, ready_d;
    logic chg_q, chg_d;
    off_t h_q, h_d, v_q, v_d;
    off_t sh_q, sh_d, sv_q, sv_d;
    off_t h_nxt, v_nxt;
    logic h_step, v_step;
    logic vb_rise, acc, c_rise;

    assign vb_rise = vblank_i & ~vblank_q;
    assign c_rise  = btn_center_i & ~center_q;
    assign acc     = cfg_valid_i & ready_q;

    offset_axis #(
        .MINV      (HMIN),
        .MAXV      (HMAX),
        .REP_DELAY (REP_DELAY),
        .REP_RATE  (REP_RATE),
        .FCW       (FCW)
    ) u_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .vb_rise_i (vb_rise),
        .inc_i     (btn_right_i),
        .dec_i     (btn_left_i),
        .cur_i     (h_q),
        .step_o    (h_step),
        .nxt_o     (h_nxt)
    );

    offset_axis #(
        .MINV      (VMIN),
        .MAXV      (VMAX),
        .REP_DELAY (REP_DELAY),
        .REP_RATE  (REP_RATE),
        .FCW       (FCW)
    ) u_v (
        .clk       (clk),
        .rst_n     (rst_n),
        .vb_rise_i (vb_rise),
        .inc_i     (btn_up_i),
        .dec_i     (btn_down_i),
        .cur_i     (v_q),
        .step_o    (v_step),
        .nxt_o     (v_nxt)
    );

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        sh_d    = sh_q;
        sv_d    = sv_q;
        pend_d  = pend_q;
        ready_d = ready_q;
        if (vb_rise && pend_q) begin
            h_d     = sh_q;
            v_d     = sv_q;
            pend_d  = 1'b0;
            ready_d = 1'b1;
        end else if (vb_rise && !acc && !c_rise) begin
            if (h_step) h_d = h_nxt;
            if (v_step) v_d = v_nxt;
        end
        // A write landing on the vb_rise cycle waits for the next frame
        if (acc) begin
            sh_d    = clamp({cfg_h_i[OFFW-1], cfg_h_i}, HMIN, HMAX);
            sv_d    = clamp({cfg_v_i[OFFW-1], cfg_v_i}, VMIN, VMAX);
            pend_d  = 1'b1;
            ready_d = 1'b0;
        end
        if (c_rise) begin
            sh_d   = '0;
            sv_d   = '0;
            pend_d = 1'b1;
        end
        chg_d = (h_d != h_q) || (v_d != v_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vblank_q <= 1'b0;
            center_q <= 1'b0;
            pend_q   <= 1'b0;
            ready_q  <= 1'b1;
            chg_q    <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            sh_q     <= '0;
            sv_q     <= '0;
        end else begin
            vblank_q <= vblank_i;
            center_q <= btn_center_i;
            pend_q   <= pend_d;
            ready_q  <= ready_d;
            chg_q    <= chg_d;
            h_q      <= h_d;
            v_q      <= v_d;
            sh_q     <= sh_d;
            sv_q     <= sv_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign hoffset_o   = h_q;
    assign voffset_o   = v_q;
    assign changed_o   = chg_q;

endmodule

// File: tb/tb_sync_offset_ctrl.sv
// Bench for sync_offset_ctrl: directed scenarios plus random traffic,
// all compared cycle by cycle with a frame-count reference model.
module tb_sync_offset_ctrl;

    localparam int RD = 20;
    localparam int RR = 4;
    localparam int MN = -8;
    localparam int MX = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vblank = 1'b0;
    logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0, bc = 1'b0;
    logic cv = 1'b0;
    logic signed [3:0] ch = '0, cvv = '0;
    logic cfg_ready;
    logic signed [3:0] hoff, voff;
    logic changed;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_offset_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vblank_i     (vblank),
        .btn_left_i   (bl),
        .btn_right_i  (br),
        .btn_up_i     (bu),
        .btn_down_i   (bd),
        .btn_center_i (bc),
        .cfg_valid_i  (cv),
        .cfg_h_i      (ch),
        .cfg_v_i      (cvv),
        .cfg_ready_o  (cfg_ready),
        .hoffset_o    (hoff),
        .voffset_o    (voff),
        .changed_o    (changed)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: steps derive from how many frames a direction is held
    int  m_h, m_v, s_h, s_v;
    int  n[2];
    int  last[2];
    bit  m_pend, m_ready, m_chg, vb_prev, c_prev;
    bit  live = 1'b0;

    function automatic int clampi(input int x);
        return (x < MN) ? MN : ((x > MX) ? MX : x);
    endfunction

    task automatic axis(input int i, input int dir, input bit vb, output bit st);
        st = 1'b0;
        if (dir == 0) begin
            n[i] = 0;
        end else if (vb) begin
            if (n[i] == 0 || dir != last[i]) n[i] = 1;
            else n[i] = n[i] + 1;
            last[i] = dir;
            st = (n[i] == 1) || (n[i] > RD && ((n[i] - 1 - RD) % RR) == 0);
        end
    endtask

    always @(posedge clk) begin
        int dh, dv, nh, nv;
        bit vb, acc, cr, sth, stv;
        if (!rst_n) begin
            m_h = 0; m_v = 0; s_h = 0; s_v = 0;
            n[0] = 0; n[1] = 0; last[0] = 0; last[1] = 0;
            m_pend = 0; m_ready = 1; m_chg = 0; vb_prev = 0; c_prev = 0;
            live = 1'b1;
        end else begin
            dh = (br && !bl) ? 1 : ((bl && !br) ? -1 : 0);
            dv = (bu && !bd) ? 1 : ((bd && !bu) ? -1 : 0);
            vb = vblank && !vb_prev;
            cr = bc && !c_prev;
            acc = cv && m_ready;
            axis(0, dh, vb, sth);
            axis(1, dv, vb, stv);
            nh = m_h;
            nv = m_v;
            if (vb && m_pend) begin
                nh = s_h; nv = s_v; m_pend = 0; m_ready = 1;
            end else if (vb && !acc && !cr) begin
                if (sth) nh = clampi(m_h + dh);
                if (stv) nv = clampi(m_v + dv);
            end
            if (acc) begin
                s_h = clampi(int'(ch)); s_v = clampi(int'(cvv));
                m_pend = 1; m_ready = 0;
            end
            if (cr) begin
                s_h = 0; s_v = 0; m_pend = 1;
            end
            m_chg = (nh != m_h) || (nv != m_v);
            m_h = nh;
            m_v = nv;
            vb_prev = vblank;
            c_prev = bc;
        end
    end

    int nchg = 0;
    bit cnt_en = 1'b0;

    always @(negedge clk) begin
        if (live) begin
            check("hoffset", int'(hoff), m_h);
            check("voffset", int'(voff), m_v);
            check("cfg_ready", int'(cfg_ready), int'(m_ready));
            check("changed", int'(changed), int'(m_chg));
            if (cnt_en && changed) nchg++;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic frame();
        vblank = 1'b0;
        cyc(6);
        vblank = 1'b1;
        cyc(2);
        vblank = 1'b0;
    endtask

    task automatic cfg(input int h, input int v);
        cv = 1'b1;
        ch = 4'(h);
        cvv = 4'(v);
        cyc(1);
        cv = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        br = 1'b1;
        frame();
        frame();
        check("rst_hoff", int'(hoff), 0);
        check("rst_voff", int'(voff), 0);
        check("rst_ready", int'(cfg_ready), 1);
        rst_n = 1'b1;
        for (int f = 1; f <= 30; f++) begin
            frame();
            if (f == 1)  check("rep_f1", int'(hoff), 1);
            if (f == 20) check("rep_f20", int'(hoff), 1);
            if (f == 21) check("rep_f21", int'(hoff), 2);
            if (f == 25) check("rep_f25", int'(hoff), 3);
            if (f == 29) check("rep_f29", int'(hoff), 4);
        end
        br = 1'b0;
        cyc(2);

        cfg(0, 6);
        frame();
        check("v_at6", int'(voff), 6);
        bu = 1'b1;
        nchg = 0;
        cnt_en = 1'b1;
        repeat (60) frame();
        cnt_en = 1'b0;
        bu = 1'b0;
        check("sat_v", int'(voff), 7);
        check("sat_chg", nchg, 1);

        cyc(3);
        cfg(-5, 3);
        check("mid_ready", int'(cfg_ready), 0);
        cyc(3);
        frame();
        check("cfg_h", int'(hoff), -5);
        check("cfg_v", int'(voff), 3);
        check("cfg_ready_back", int'(cfg_ready), 1);

        bl = 1'b1;
        frame();
        check("left1", int'(hoff), -6);
        vblank = 1'b0;
        cyc(6);
        vblank = 1'b1;
        cv = 1'b1;
        ch = 4'sd2;
        cvv = -4'sd2;
        cyc(1);
        cv = 1'b0;
        check("vbacc_hold", int'(hoff), -6);
        check("vbacc_ready", int'(cfg_ready), 0);
        cyc(1);
        vblank = 1'b0;
        frame();
        check("vbacc_h", int'(hoff), 2);
        check("vbacc_v", int'(voff), -2);
        bl = 1'b0;
        cyc(2);

        bl = 1'b1;
        br = 1'b1;
        nchg = 0;
        cnt_en = 1'b1;
        repeat (10) frame();
        cnt_en = 1'b0;
        check("both_h", int'(hoff), 2);
        check("both_chg", nchg, 0);
        bl = 1'b0;
        br = 1'b0;

        cfg(-8, 0);
        frame();
        bl = 1'b1;
        repeat (3) frame();
        check("clamp_lo", int'(hoff), -8);
        bl = 1'b0;

        bc = 1'b1;
        frame();
        check("center_h", int'(hoff), 0);
        check("center_v", int'(voff), 0);
        bc = 1'b0;

        repeat (400) begin
            int lo, hi;
            lo = int'($urandom_range(2, 8));
            hi = int'($urandom_range(1, 3));
            vblank = 1'b0;
            for (int c = 0; c < lo + hi; c++) begin
                if (c == lo) vblank = 1'b1;
                if ($urandom_range(0, 79) == 0) {bl, br, bu, bd} = 4'($urandom);
                if ($urandom_range(0, 40) == 0) bc = ~bc;
                cv = ($urandom_range(0, 5) == 0);
                ch = 4'($urandom);
                cvv = 4'($urandom);
                rst_n = ($urandom_range(0, 599) != 0);
                cyc(1);
            end
        end
        rst_n = 1'b1;
        cv = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
